// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: button command stage feeding a synchronous JK flip-flop.
// Ports: CK/RB clock and async active-low reset, BTN_SET/BTN_CLR/BTN_TGL raw
// buttons, J/K registered one-cycle commands, BUSY (FSM not idle),
// DROP (one-cycle pulse when a debounced press is discarded).
module jk_cmd_gen #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic CK,
  input  logic RB,
  input  logic BTN_SET,
  input  logic BTN_CLR,
  input  logic BTN_TGL,
  output logic J,
  output logic K,
  output logic BUSY,
  output logic DROP
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bit order for all per-button vectors: [0]=SET, [1]=CLR, [2]=TGL.
  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_deb;
  logic [2:0]       r_deb_d;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       w_rise;
  logic             w_multi;

  state_t r_state;
  state_t w_next;

  logic r_j;
  logic r_k;
  logic r_drop;
  logic w_j_nxt;
  logic w_k_nxt;
  logic w_drop_nxt;

  assign w_raw = {BTN_TGL, BTN_CLR, BTN_SET};

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DB_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt   <= '{default: '0};
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise  = r_deb & ~r_deb_d;
  assign w_multi = (w_rise[0] & w_rise[1])
                 | (w_rise[0] & w_rise[2])
                 | (w_rise[1] & w_rise[2]);

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (|w_rise) w_next = ISSUE;
      ISSUE:   w_next = HOLD;
      HOLD:    if (r_deb == 3'b000) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Commands are computed here and registered so J/K are high exactly
  // during the ISSUE cycle.
  always_comb begin
    w_j_nxt    = 1'b0;
    w_k_nxt    = 1'b0;
    w_drop_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise[1]) begin
          w_k_nxt = 1'b1;
        end else if (w_rise[0]) begin
          w_j_nxt = 1'b1;
        end else if (w_rise[2]) begin
          w_j_nxt = 1'b1;
          w_k_nxt = 1'b1;
        end
        w_drop_nxt = w_multi;
      end
      ISSUE,
      HOLD:    w_drop_nxt = |w_rise;
      default: w_drop_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_j    <= 1'b0;
      r_k    <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_j    <= w_j_nxt;
      r_k    <= w_k_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign J    = r_j;
  assign K    = r_k;
  assign DROP = r_drop;
  assign BUSY = (r_state != IDLE);

endmodule
